// File: rtl/digit_serial_addsub_pkg.sv
// Shared types for the digit-serial add/subtract unit: FSM states and operation select.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } addsub_state_t;

  typedef enum logic {
    OP_SUB = 1'b0,
    OP_ADD = 1'b1
  } addsub_op_t;

endpackage

// File: rtl/digit_serial_addsub_digit.sv
// Combinational DIGIT-wide ripple slice; the chain bit is a borrow when subtracting, a carry when adding.
module digit_addsub
  import addsub_pkg::*;
#(
  parameter int DIGIT = 2
) (
  input  addsub_op_t       mode,
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             chain_in,
  output logic [DIGIT-1:0] y_d,
  output logic             chain_out
);

  logic [DIGIT:0] chain;

  assign chain[0] = chain_in;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign y_d[i]       = a_d[i] ^ b_d[i] ^ chain[i];
    assign chain[i+1]   = (mode == OP_ADD)
                        ? ((a_d[i] & b_d[i]) | (chain[i] & (a_d[i] ^ b_d[i])))
                        : ((~a_d[i] & b_d[i]) | (chain[i] & ~(a_d[i] ^ b_d[i])));
  end

  assign chain_out = chain[DIGIT];

endmodule

// File: rtl/digit_serial_addsub.sv
// Digit-serial add/subtract: one DIGIT-wide slice iterated WIDTH/DIGIT times, LSB digit first.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | one digit computed per edge
//   DONE  | one-cycle done pulse; start here is accepted back-to-back
module digit_serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N) + 1;

  if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("digit_serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  addsub_state_t    state, state_nxt;
  addsub_op_t       op_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q, b_q, a_sh, b_sh, acc, acc_nxt;
  logic             chain_q, a_msb, b_msb;
  logic [DIGIT-1:0] y_d;
  logic             chain_out;
  logic             last, accept, ovf_nxt;

  assign last   = (cnt == CW'(N - 1));
  assign accept = (state != RUN) && start;
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  digit_addsub #(.DIGIT(DIGIT)) u_digit (
    .mode      (op_q),
    .a_d       (a_q[DIGIT-1:0]),
    .b_d       (b_q[DIGIT-1:0]),
    .chain_in  (chain_q),
    .y_d       (y_d),
    .chain_out (chain_out)
  );

  // Operands shift down so the slice always sees bit 0; the accumulator fills from the top.
  if (DIGIT == WIDTH) begin : g_single
    assign a_sh    = '0;
    assign b_sh    = '0;
    assign acc_nxt = y_d;
  end else begin : g_multi
    assign a_sh    = {{DIGIT{1'b0}}, a_q[WIDTH-1:DIGIT]};
    assign b_sh    = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
    assign acc_nxt = {y_d, acc[WIDTH-1:DIGIT]};
  end

  assign ovf_nxt = (op_q == OP_ADD)
                 ? ((a_msb == b_msb) && (acc_nxt[WIDTH-1] != a_msb))
                 : ((a_msb != b_msb) && (acc_nxt[WIDTH-1] != a_msb));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = start ? RUN : IDLE;
      RUN:        if (last) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_SUB;
      a_q      <= '0;
      b_q      <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      acc      <= '0;
      chain_q  <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      cout     <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      op_q    <= addsub_op_t'(mode);
      a_q     <= a;
      b_q     <= b;
      a_msb   <= a[WIDTH-1];
      b_msb   <= b[WIDTH-1];
      chain_q <= 1'b0;
      cnt     <= '0;
    end else if (state == RUN) begin
      a_q     <= a_sh;
      b_q     <= b_sh;
      acc     <= acc_nxt;
      chain_q <= chain_out;
      cnt     <= cnt + 1'b1;
      if (last) begin
        result   <= acc_nxt;
        cout     <= chain_out;
        zero     <= (acc_nxt == '0);
        negative <= acc_nxt[WIDTH-1];
        overflow <= ovf_nxt;
      end
    end
  end

endmodule

// File: doc/digit_serial_addsub.md
Name: digit_serial_addsub

Overview:
Multi-cycle, parametrised add/subtract unit that processes operands DIGIT bits per clock, LSB digit first. It generalises the per-bit borrow chain to WIDTH bits and adds an add mode, a start/busy/done handshake and NZCV-style status flags. It sits behind the lab ALU front-end and trades latency for area: one DIGIT-wide slice, iterated WIDTH/DIGIT times.

Parameters:
WIDTH, 8, operand/result width in bits; must be at least 2.
DIGIT, 2, bits processed per cycle; WIDTH % DIGIT == 0 (elaboration-time assertion); DIGIT == WIDTH gives single-cycle compute.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  request; sampled only when not busy.
mode  in  1  0 = subtract (a - b), 1 = add (a + b); latched with start.
a  in  WIDTH  minuend / addend A; latched with start.
b  in  WIDTH  subtrahend / addend B; latched with start.
busy  out  1  high while an operation is in progress.
done  out  1  one-cycle pulse; result and flags updated on the same edge.
result  out  WIDTH  last completed result, modulo 2^WIDTH.
cout  out  1  final borrow (subtract) or final carry (add).
zero  out  1  result == 0.
negative  out  1  result[WIDTH-1].
overflow  out  1  signed two's-complement overflow.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; busy, done, result, cout, zero, negative and overflow are all 0; digit counter and internal chain bit cleared.
- Let N = WIDTH/DIGIT. FSM states: IDLE, RUN, DONE.
- IDLE or DONE with start = 1 at edge E0:
  - latch a, b and mode;
  - clear the chain bit (borrow_in = 0 for subtract, carry_in = 0 for add);
  - counter = 0; go to RUN; busy = 1 from E0.
- IDLE or DONE with start = 0: go to or stay in IDLE; done = 0.
- RUN, edge Ek for k = 1..N:
  - compute digit k-1 from latched bits [k*DIGIT-1 : (k-1)*DIGIT] and the chain bit;
  - store the digit into the internal accumulator and register its chain-out;
  - increment the counter.
- Edge EN completes the last digit and moves RUN -> DONE:
  - done = 1 and busy = 0;
  - result, cout, zero, negative and overflow are loaded from the completed accumulator.
- Latency: done rises N edges after the start-sampling edge. WIDTH = 8, DIGIT = 2 gives 4 cycles.
- Back-to-back operation: start sampled in DONE is accepted, giving throughput of one operation per N+1 cycles.
- done lasts exactly one cycle unless a new operation completes.
- start while busy (RUN) is ignored. It is not queued, and latched operands are unaffected by input changes.
- result and flags hold their last value until the next done. Partial sums are never visible on result.
- Per-bit arithmetic:
  - subtract: d = a^b^bin; bout = (~a&b) | (bin&~(a^b));
  - add: s = a^b^cin; cout = (a&b) | (cin&(a^b)).
- Overflow:
  - subtract: (a[msb] != b[msb]) && (result[msb] != a[msb]);
  - add: (a[msb] == b[msb]) && (result[msb] != a[msb]).
- Reset asserted mid-RUN aborts the operation. All outputs return to their reset values, done is not pulsed, and the next start begins fresh.
- mode, a and b are don't-care except at the accepting edge.

Decomposition:
- Package addsub_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} addsub_state_t;
  - typedef enum logic {OP_SUB = 1'b0, OP_ADD = 1'b1} addsub_op_t.
- Counter width is $clog2(WIDTH/DIGIT) + 1, computed locally from the parameters.
- One sub-module, digit_addsub:
  - purely combinational DIGIT-wide ripple slice;
  - inputs: mode, a_d, b_d, chain_in; outputs: y_d, chain_out;
  - built as a generate loop of the per-bit equations above.
- Top level holds the FSM, counter, operand/accumulator registers and flag logic.

Test Plan:
- WIDTH=8, DIGIT=2, sub, a=0x05, b=0x03 -> done exactly 4 cycles after start edge; result=0x02, cout=0, zero=0, negative=0, overflow=0; busy high during the 4 RUN cycles.
- sub, a=0x03, b=0x05 -> result=0xFE, cout=1, negative=1, overflow=0. Then sub, a=0x80, b=0x01 -> result=0x7F, cout=0, overflow=1.
- add, a=0xFF, b=0x01 -> result=0x00, cout=1, zero=1, overflow=0. Then add, a=0x7F, b=0x01 -> result=0x80, negative=1, overflow=1.
- Busy and back-to-back handling:
  - start sub 0x10-0x01 and, in the second RUN cycle, pulse start with a=0xAA and change a and b -> result=0x0F and a single done, new request ignored;
  - assert start in the DONE cycle -> second operation accepted, done spacing 5 cycles.
- Reset mid-operation: drop rst_n asynchronously (between edges) in the 2nd RUN cycle -> busy, done, result and flags are 0 immediately and no done pulse occurs; a following sub 0x09-0x09 gives result=0x00, zero=1.
- Parameter sweep DIGIT=1, DIGIT=4 and DIGIT=8 (WIDTH=8):
  - 256 random pairs per mode checked against a behavioural a±b model;
  - latency equals 8, 2 and 1 cycles respectively.
